// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES round sequencer and its datapath controls.
package aes_pkg;

  typedef logic [7:0]  aes_byte;
  typedef logic [31:0] aes_32;

  // Encodings 5..7 are undefined and are flagged as illegal when accepted.
  typedef enum logic [2:0] {
    OP_NOOP            = 3'd0,
    OP_AESENC          = 3'd1,
    OP_AESENCLAST      = 3'd2,
    OP_AESKEYGENASSIST = 3'd3,
    OP_AESENCFULL      = 3'd4
  } opcode;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SBOX   = 2'd1,
    ST_ROUND  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  localparam aes_byte RCON_INIT = 8'h01;

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

  // GF(2^8) doubling: 80 wraps to 1B.
  function automatic aes_byte rcon_next(input aes_byte rc);
    return rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1B) : {rc[6:0], 1'b0};
  endfunction

  function automatic logic is_legal_op(input opcode op);
    logic legal;
    case (op)
      OP_AESENC, OP_AESENCLAST, OP_AESKEYGENASSIST, OP_AESENCFULL: legal = 1'b1;
      default:                                                     legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reload to 01, advance by xtime, otherwise hold.
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    reload,
  input  logic    advance,
  output aes_byte rcon
);

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      rcon <= RCON_INIT;
    end else if (advance) begin
      rcon <= rcon_next(rcon);
    end
  end

endmodule

// File: rtl/aes_round_seq.sv
// Sequencer driving the aes_enc / S_box / key_gen datapath for single-round ops
// and full AES-128/AES-256 encryption.
module aes_round_seq
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  opcode       opcode_i,
  input  logic        abort_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        full_enc_o,
  output logic        zero_rnd_o,
  output logic        key_sel_o,
  output logic        final_rnd_o,
  output logic        en_rnd_o,
  output logic        key_sub_o,
  output logic        en_key_o,
  output logic        gen_key_o,
  output logic        next_rnd_o,
  output logic        key_rot_o,
  output logic        cipher_ready_o,
  output logic        key_ready_o,
  output logic [3:0]  rnd_num_o,
  output aes_32       r_con_o,
  output logic [1:0]  state_o
);

  localparam int         NR     = nr_of(KEY_BITS);
  localparam logic [3:0] NR_V   = NR[3:0];
  localparam bit         IS_256 = (KEY_BITS == 256);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_seq: KEY_BITS must be 128 or 256");
  end

  seq_state_e state_q, state_d;
  opcode      op_q;
  logic [3:0] rnd_q;
  logic       err_q;
  logic       accept;
  logic       rot_now;
  logic       rcon_reload;
  logic       rcon_advance;
  aes_byte    rcon;

  // Handshake: ready_o is high in IDLE/FINISH unless abort_i is asserted; a
  // request is taken on any clock edge where start_i and ready_o are both high,
  // and opcode_i is captured on that same edge.
  assign ready_o = ((state_q == ST_IDLE) || (state_q == ST_FINISH)) && !abort_i;
  assign accept  = start_i && ready_o;

  assign rot_now = IS_256 ? ~rnd_q[0] : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !is_legal_op(opcode_i);
      if (accept) begin
        op_q <= opcode_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FINISH: begin
          state_d = ST_IDLE;
          if (accept) begin
            case (opcode_i)
              OP_AESENC, OP_AESENCLAST, OP_AESENCFULL: state_d = ST_SBOX;
              OP_AESKEYGENASSIST:                      state_d = ST_ROUND;
              default:                                 state_d = ST_IDLE;
            endcase
          end
        end
        ST_SBOX:  state_d = ST_ROUND;
        ST_ROUND: state_d = (op_q == OP_AESENCFULL && rnd_q < NR_V) ? ST_SBOX : ST_FINISH;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The round counter only moves during a full cipher; every path back to IDLE clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q <= 4'd0;
    end else if (accept || state_d == ST_IDLE) begin
      rnd_q <= 4'd0;
    end else if (state_q == ST_SBOX && op_q == OP_AESENCFULL && rnd_q < NR_V) begin
      rnd_q <= rnd_q + 4'd1;
    end
  end

  always_comb begin
    busy_o         = 1'b0;
    full_enc_o     = 1'b0;
    zero_rnd_o     = 1'b0;
    key_sel_o      = 1'b0;
    final_rnd_o    = 1'b0;
    en_rnd_o       = 1'b1;
    key_sub_o      = 1'b0;
    en_key_o       = 1'b1;
    gen_key_o      = 1'b0;
    next_rnd_o     = 1'b0;
    key_rot_o      = 1'b0;
    cipher_ready_o = 1'b0;
    key_ready_o    = 1'b0;
    case (state_q)
      ST_SBOX: begin
        busy_o = 1'b1;
        if (op_q == OP_AESENCFULL) begin
          key_sub_o  = 1'b1;
          gen_key_o  = 1'b1;
          zero_rnd_o = (rnd_q == 4'd0);
          key_sel_o  = (rnd_q == 4'd0);
        end else begin
          en_key_o = 1'b0;
        end
      end
      ST_ROUND: begin
        busy_o = 1'b1;
        case (op_q)
          OP_AESENC: begin
            full_enc_o = 1'b1;
            zero_rnd_o = 1'b1;
            key_sel_o  = 1'b1;
          end
          OP_AESENCLAST: begin
            final_rnd_o = 1'b1;
            zero_rnd_o  = 1'b1;
          end
          OP_AESKEYGENASSIST: begin
            key_sub_o = 1'b1;
            en_rnd_o  = 1'b0;
            key_rot_o = 1'b1;
          end
          OP_AESENCFULL: begin
            next_rnd_o  = 1'b1;
            key_sub_o   = 1'b1;
            final_rnd_o = (rnd_q == NR_V);
            full_enc_o  = (rnd_q != NR_V);
            key_rot_o   = rot_now;
          end
          default: ;
        endcase
      end
      ST_FINISH: begin
        if (op_q == OP_AESKEYGENASSIST) begin
          key_ready_o = 1'b1;
        end else begin
          cipher_ready_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Rcon is not advanced past the last round so FINISH still shows the last value used.
  assign rcon_reload  = accept || (state_d == ST_IDLE);
  assign rcon_advance = (state_q == ST_ROUND) && (op_q == OP_AESENCFULL) && rot_now &&
                        (rnd_q < NR_V);

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .rst     (rst),
    .reload  (rcon_reload),
    .advance (rcon_advance),
    .rcon    (rcon)
  );

  assign err_o     = err_q;
  assign rnd_num_o = rnd_q;
  assign r_con_o   = {rcon, 24'h00_0000};
  assign state_o   = state_q;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: one AES-128 and one AES-256 instance share stimulus.
module tb_aes_round_seq;
  import aes_pkg::*;

  logic  clk = 1'b0;
  logic  rst, start_i, abort_i;
  opcode opcode_i;

  always #5 clk = ~clk;

  logic        ready_a, busy_a, err_a, full_enc_a, zero_rnd_a, key_sel_a, final_rnd_a;
  logic        en_rnd_a, key_sub_a, en_key_a, gen_key_a, next_rnd_a, key_rot_a;
  logic        cipher_ready_a, key_ready_a;
  logic [3:0]  rnd_num_a;
  logic [31:0] r_con_a;
  logic [1:0]  state_a;
  logic        ready_b, busy_b, err_b, full_enc_b, zero_rnd_b, key_sel_b, final_rnd_b;
  logic        en_rnd_b, key_sub_b, en_key_b, gen_key_b, next_rnd_b, key_rot_b;
  logic        cipher_ready_b, key_ready_b;
  logic [3:0]  rnd_num_b;
  logic [31:0] r_con_b;
  logic [1:0]  state_b;

  aes_round_seq #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .abort_i(abort_i),
    .ready_o(ready_a), .busy_o(busy_a), .err_o(err_a), .full_enc_o(full_enc_a),
    .zero_rnd_o(zero_rnd_a), .key_sel_o(key_sel_a), .final_rnd_o(final_rnd_a),
    .en_rnd_o(en_rnd_a), .key_sub_o(key_sub_a), .en_key_o(en_key_a), .gen_key_o(gen_key_a),
    .next_rnd_o(next_rnd_a), .key_rot_o(key_rot_a), .cipher_ready_o(cipher_ready_a),
    .key_ready_o(key_ready_a), .rnd_num_o(rnd_num_a), .r_con_o(r_con_a), .state_o(state_a)
  );

  aes_round_seq #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .opcode_i(opcode_i), .abort_i(abort_i),
    .ready_o(ready_b), .busy_o(busy_b), .err_o(err_b), .full_enc_o(full_enc_b),
    .zero_rnd_o(zero_rnd_b), .key_sel_o(key_sel_b), .final_rnd_o(final_rnd_b),
    .en_rnd_o(en_rnd_b), .key_sub_o(key_sub_b), .en_key_o(en_key_b), .gen_key_o(gen_key_b),
    .next_rnd_o(next_rnd_b), .key_rot_o(key_rot_b), .cipher_ready_o(cipher_ready_b),
    .key_ready_o(key_ready_b), .rnd_num_o(rnd_num_b), .r_con_o(r_con_b), .state_o(state_b)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rcon_tab[10];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input opcode op);
    start_i  = 1'b1;
    opcode_i = op;
  endtask

  // zeros = {err, full_enc, zero_rnd, key_sel, final_rnd, key_sub, gen_key, next_rnd,
  //          key_rot, cipher_ready, key_ready}; ens = {en_rnd, en_key}
  task automatic check_idle(input string tag, input logic [1:0] st, input logic rdy,
                            input logic bsy, input logic [3:0] rnd, input logic [31:0] rc,
                            input logic [10:0] zeros, input logic [1:0] ens);
    check({tag, "_state"}, 32'(st), 32'd0);
    check({tag, "_ready"}, 32'(rdy), 32'd1);
    check({tag, "_busy"}, 32'(bsy), 32'd0);
    check({tag, "_rnd"}, 32'(rnd), 32'd0);
    check({tag, "_rcon"}, rc, 32'h0100_0000);
    check({tag, "_zeros"}, 32'(zeros), 32'd0);
    check({tag, "_ens"}, 32'(ens), 32'd3);
  endtask

  task automatic idle_both(input string tag);
    check_idle({tag, "_a"}, state_a, ready_a, busy_a, rnd_num_a, r_con_a,
               {err_a, full_enc_a, zero_rnd_a, key_sel_a, final_rnd_a, key_sub_a, gen_key_a,
                next_rnd_a, key_rot_a, cipher_ready_a, key_ready_a}, {en_rnd_a, en_key_a});
    check_idle({tag, "_b"}, state_b, ready_b, busy_b, rnd_num_b, r_con_b,
               {err_b, full_enc_b, zero_rnd_b, key_sel_b, final_rnd_b, key_sub_b, gen_key_b,
                next_rnd_b, key_rot_b, cipher_ready_b, key_ready_b}, {en_rnd_b, en_key_b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  r;
    logic seen;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    rst      = 1'b1;
    start_i  = 1'b0;
    abort_i  = 1'b0;
    opcode_i = OP_NOOP;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    idle_both("reset");

    // Full cipher on both key sizes at once.
    for (int i = 0; i < 10; i++) exp_q.push_back(rcon_tab[i]);
    tick();
    issue(OP_AESENCFULL);
    #1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      start_i = 1'b0;
      #1;
      check($sformatf("full128_done_c%0d", c), 32'(cipher_ready_a), 32'(c == 21));
      check($sformatf("full256_done_c%0d", c), 32'(cipher_ready_b), 32'(c == 29));
      if (c <= 20) begin
        if (c % 2 == 1) begin
          check($sformatf("full128_sbox_c%0d", c), {gen_key_a, rnd_num_a}, {1'b1, 4'((c - 1) / 2)});
        end else begin
          r = c / 2;
          check($sformatf("full128_rnd_c%0d", c), 32'(rnd_num_a), 32'(r));
          check($sformatf("full128_final_c%0d", c), 32'(final_rnd_a), 32'(r == 10));
          check($sformatf("full128_rot_c%0d", c), {next_rnd_a, key_rot_a}, 2'b11);
          if (exp_q.size() > 0) check($sformatf("full128_rcon_r%0d", r), r_con_a, {exp_q.pop_front(), 24'h0});
        end
      end
      if (c <= 28) begin
        if (c % 2 == 1) begin
          check($sformatf("full256_sbox_c%0d", c), {gen_key_b, rnd_num_b}, {1'b1, 4'((c - 1) / 2)});
        end else begin
          r = c / 2;
          check($sformatf("full256_rnd_c%0d", c), 32'(rnd_num_b), 32'(r));
          check($sformatf("full256_final_c%0d", c), 32'(final_rnd_b), 32'(r == 14));
          check($sformatf("full256_rot_c%0d", c), 32'(key_rot_b), 32'(r % 2 == 0));
          check($sformatf("full256_rcon_r%0d", r), r_con_b, {rcon_tab[(r - 1) / 2], 24'h0});
        end
      end
      if (c == 22) check("full128_back_idle", {state_a, rnd_num_a, r_con_a}, {2'd0, 4'd0, 32'h0100_0000});
    end
    check("full128_rcon_q_empty", 32'(exp_q.size()), 32'd0);
    idle_both("after_full");

    // AESENC then AESKEYGENASSIST issued in FINISH.
    tick(); issue(OP_AESENC); #1;
    tick(); start_i = 1'b0; #1;
    check("enc_c1", {state_a, busy_a, en_key_a}, {2'd1, 1'b1, 1'b0});
    tick(); #1;
    check("enc_c2", {state_a, full_enc_a, zero_rnd_a, key_sel_a, final_rnd_a, cipher_ready_a},
          {2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tick(); issue(OP_AESKEYGENASSIST); #1;
    check("enc_c3", {state_a, cipher_ready_a, ready_a, key_ready_a}, {2'd3, 1'b1, 1'b1, 1'b0});
    tick(); start_i = 1'b0; #1;
    check("kga_c4", {state_a, key_sub_a, en_rnd_a, key_ready_a, cipher_ready_a},
          {2'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    tick(); #1;
    check("kga_c5", {state_a, key_ready_a, cipher_ready_a, ready_a}, {2'd3, 1'b1, 1'b0, 1'b1});
    tick(); #1;
    check("kga_c6", {state_a, key_ready_a}, {2'd0, 1'b0});

    // AESENCLAST on the 256-bit instance.
    tick(); issue(OP_AESENCLAST); #1;
    tick(); start_i = 1'b0; #1;
    tick(); #1;
    check("last_c2", {state_b, final_rnd_b, full_enc_b, zero_rnd_b}, {2'd2, 1'b1, 1'b0, 1'b1});
    tick(); #1;
    check("last_c3", {cipher_ready_b, key_ready_b}, 2'b10);

    // Abort at round 5 of a full cipher.
    tick(); issue(OP_AESENCFULL); #1;
    for (int c = 1; c <= 10; c++) begin
      tick(); start_i = 1'b0; #1;
    end
    check("abort_pre_rnd", {rnd_num_a, rnd_num_b, busy_a}, {4'd5, 4'd5, 1'b1});
    abort_i = 1'b1;
    tick(); abort_i = 1'b0; #1;
    check("abort_idle_a", {state_a, rnd_num_a, r_con_a, ready_a}, {2'd0, 4'd0, 32'h0100_0000, 1'b1});
    check("abort_idle_b", {state_b, rnd_num_b, r_con_b, ready_b}, {2'd0, 4'd0, 32'h0100_0000, 1'b1});
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      tick(); #1;
      seen |= cipher_ready_a | cipher_ready_b | key_ready_a | key_ready_b;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Abort together with start while idle: ready drops and nothing is accepted.
    tick(); issue(OP_AESENC); abort_i = 1'b1; #1;
    check("abort_ready_low", {ready_a, ready_b}, 2'b00);
    tick(); start_i = 1'b0; abort_i = 1'b0; #1;
    check("abort_no_accept", {state_a, busy_a}, {2'd0, 1'b0});

    // NOOP and an undefined encoding raise err for one cycle only.
    tick(); issue(OP_NOOP); #1;
    tick(); start_i = 1'b0; #1;
    check("noop_err_c1", {err_a, err_b, ready_a, state_a}, {1'b1, 1'b1, 1'b1, 2'd0});
    tick(); #1;
    check("noop_err_c2", {err_a, err_b}, 2'b00);
    tick(); issue(opcode'(3'd7)); #1;
    tick(); start_i = 1'b0; #1;
    check("undef_err_c1", {err_a, state_a, busy_a}, {1'b1, 2'd0, 1'b0});
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      seen |= cipher_ready_a | key_ready_a | err_a;
    end
    check("undef_quiet", 32'(seen), 32'd0);

    // Reset in the middle of a full cipher.
    tick(); issue(OP_AESENCFULL); #1;
    repeat (5) begin
      tick(); start_i = 1'b0;
    end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    idle_both("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
